// File: rtl/neo_pkg.sv
// Shared definitions for the NEO-C1 bus-cycle controller: FSM states,
// zone indices and the default wait-state assignment per zone.
package neo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXTW,
    S_ACK,
    S_BERR
  } bus_state_e;

  localparam int unsigned ZONE_ROM     = 0;
  localparam int unsigned ZONE_PORT    = 1;
  localparam int unsigned ZONE_MEMCARD = 2;
  localparam int unsigned ZONE_IO      = 3;

  localparam int unsigned ROM_WS     = 0;
  localparam int unsigned PORT_WS    = 0;
  localparam int unsigned MEMCARD_WS = 2;
  localparam int unsigned IO_WS      = 0;

endpackage

// File: rtl/neo_watchdog.sv
// System watchdog: free-running counter cleared by a kick; on reaching the
// terminal count it emits an active-low reset request of fixed length.
module neo_watchdog #(
  parameter int unsigned WDW      = 20,
  parameter int unsigned WD_LIMIT = 786432,
  parameter int unsigned WD_PULSE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic kick_i,
  output logic nwdreset_o
);

  localparam int unsigned PW = $clog2(WD_PULSE + 1);

  logic [WDW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]  pulse_q, pulse_d;
  logic           nrst_q, nrst_d;

  // Next-state: count, honour kicks outside the pulse, start pulse at terminal count.
  always_comb begin
    cnt_d   = cnt_q + WDW'(1);
    pulse_d = pulse_q;
    nrst_d  = nrst_q;
    if (!nrst_q) begin
      if (pulse_q == '0) nrst_d = 1'b1;
      else               pulse_d = pulse_q - PW'(1);
    end
    if (kick_i && nrst_q) begin
      cnt_d = '0;
    end else if (cnt_q == WDW'(WD_LIMIT - 1)) begin
      cnt_d   = '0;
      nrst_d  = 1'b0;
      pulse_d = PW'(WD_PULSE - 1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      pulse_q <= '0;
      nrst_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      nrst_q  <= nrst_d;
    end
  end

  assign nwdreset_o = nrst_q;

endmodule

// File: rtl/neo_buscycle.sv
// 68k bus-cycle controller: per-zone wait states, optional cartridge DTACK
// termination, bus-error timeout and the system watchdog.
module neo_buscycle
  import neo_pkg::*;
#(
  parameter int unsigned NZONES   = 4,
  parameter int unsigned WSW      = 3,
  parameter int unsigned TOW      = 8,
  parameter int unsigned TIMEOUT  = 200,
  parameter int unsigned WDW      = 20,
  parameter int unsigned WD_LIMIT = 786432,
  parameter int unsigned WD_PULSE = 16
) (
  input  logic                      CLK_68KCLK,
  input  logic                      RESET,
  input  logic                      nAS,
  input  logic [NZONES-1:0]         ZONE_SEL,
  input  logic [NZONES*WSW-1:0]     ZONE_WS,
  input  logic [NZONES-1:0]         ZONE_EXT,
  input  logic                      nPDTACK,
  input  logic                      WDKICK,
  output logic                      nDTACK,
  output logic                      nBERR,
  output logic                      nWDRESET,
  output logic [$clog2(NZONES)-1:0] CUR_ZONE
);

  localparam int unsigned ZW = $clog2(NZONES);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  bus_state_e     state_q, state_d;
  logic [WSW-1:0] ws_q, ws_d;
  logic [TOW-1:0] to_q, to_d;
  logic           ext_q, ext_d;
  logic           unmapped_q, unmapped_d;
  logic [ZW-1:0]  zone_q, zone_d;
  logic           ndtack_q, ndtack_d;
  logic           nberr_q, nberr_d;

  logic           hit;
  logic [ZW-1:0]  sel_idx;
  logic [WSW-1:0] sel_ws;
  logic           sel_ext;
  logic [TOW-1:0] to_inc;

  // Priority decode: lowest set ZONE_SEL bit wins.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NZONES; i++) begin
      if (ZONE_SEL[i] && !hit) begin
        hit     = 1'b1;
        sel_idx = ZW'(i);
      end
    end
  end

  assign sel_ws  = ZONE_WS[sel_idx*WSW +: WSW];
  assign sel_ext = ZONE_EXT[sel_idx];
  assign to_inc  = (to_q == TO_LAST) ? to_q : to_q + TOW'(1);

  // Bus FSM next-state and registered-output next values.
  always_comb begin
    state_d    = state_q;
    ws_d       = ws_q;
    to_d       = to_q;
    ext_d      = ext_q;
    unmapped_d = unmapped_q;
    zone_d     = zone_q;
    ndtack_d   = 1'b1;
    nberr_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!nAS) begin
          to_d = '0;
          if (!hit) begin
            unmapped_d = 1'b1;
            ext_d      = 1'b0;
            ws_d       = '0;
            state_d    = S_WAIT;
          end else begin
            unmapped_d = 1'b0;
            ws_d       = sel_ws;
            ext_d      = sel_ext;
            zone_d     = sel_idx;
            if (sel_ws != '0)  state_d = S_WAIT;
            else if (sel_ext)  state_d = S_EXTW;
            else               state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (nAS) begin
          state_d = S_IDLE;
        end else begin
          to_d = to_inc;
          if (!unmapped_q && ws_q <= WSW'(1)) begin
            ws_d    = '0;
            state_d = ext_q ? S_EXTW : S_ACK;
          end else begin
            if (!unmapped_q) ws_d = ws_q - WSW'(1);
            if (to_inc == TO_LAST) state_d = S_BERR;
          end
        end
      end
      S_EXTW: begin
        if (nAS) begin
          state_d = S_IDLE;
        end else begin
          to_d = to_inc;
          if (!nPDTACK)               state_d = S_ACK;
          else if (to_inc == TO_LAST) state_d = S_BERR;
        end
      end
      S_ACK: begin
        if (nAS) state_d  = S_IDLE;
        else     ndtack_d = 1'b0;
      end
      S_BERR: begin
        if (nAS) state_d = S_IDLE;
        else     nberr_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus FSM state and output registers.
  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      ws_q       <= '0;
      to_q       <= '0;
      ext_q      <= 1'b0;
      unmapped_q <= 1'b0;
      zone_q     <= '0;
      ndtack_q   <= 1'b1;
      nberr_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ws_q       <= ws_d;
      to_q       <= to_d;
      ext_q      <= ext_d;
      unmapped_q <= unmapped_d;
      zone_q     <= zone_d;
      ndtack_q   <= ndtack_d;
      nberr_q    <= nberr_d;
    end
  end

  assign nDTACK   = ndtack_q;
  assign nBERR    = nberr_q;
  assign CUR_ZONE = zone_q;

  neo_watchdog #(
    .WDW      (WDW),
    .WD_LIMIT (WD_LIMIT),
    .WD_PULSE (WD_PULSE)
  ) u_wd (
    .clk_i      (CLK_68KCLK),
    .rst_i      (RESET),
    .kick_i     (WDKICK),
    .nwdreset_o (nWDRESET)
  );

endmodule

// File: tb/tb_neo_buscycle.sv
// Directed-vector bench for neo_buscycle.
module tb_neo_buscycle;
  import neo_pkg::*;

  logic        clk;
  logic        RESET;
  logic        nAS;
  logic [3:0]  ZONE_SEL;
  logic [11:0] ZONE_WS;
  logic [3:0]  ZONE_EXT;
  logic        nPDTACK;
  logic        WDKICK;
  logic        nDTACK;
  logic        nBERR;
  logic        nWDRESET;
  logic [1:0]  CUR_ZONE;

  int n_vec;
  int n_err;

  neo_buscycle #(
    .NZONES   (4),
    .WSW      (3),
    .TOW      (8),
    .TIMEOUT  (20),
    .WDW      (20),
    .WD_LIMIT (100),
    .WD_PULSE (16)
  ) dut (
    .CLK_68KCLK (clk),
    .RESET      (RESET),
    .nAS        (nAS),
    .ZONE_SEL   (ZONE_SEL),
    .ZONE_WS    (ZONE_WS),
    .ZONE_EXT   (ZONE_EXT),
    .nPDTACK    (nPDTACK),
    .WDKICK     (WDKICK),
    .nDTACK     (nDTACK),
    .nBERR      (nBERR),
    .nWDRESET   (nWDRESET),
    .CUR_ZONE   (CUR_ZONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  // nAS low sampled at edge k; nDTACK expected low after edge k+lat.
  task automatic bus_cycle(input string tag, input logic [3:0] sel, input int lat,
                           input int zone);
    nAS = 1'b0;
    ZONE_SEL = sel;
    step();
    check($sformatf("%s k", tag), 32'(nDTACK), 1);
    for (int j = 1; j <= lat; j++) begin
      step();
      check($sformatf("%s dtack%0d", tag, j), 32'(nDTACK), (j == lat) ? 0 : 1);
      check($sformatf("%s berr%0d", tag, j), 32'(nBERR), 1);
    end
    check($sformatf("%s zone", tag), 32'(CUR_ZONE), 32'(zone));
    nAS = 1'b1;
    ZONE_SEL = '0;
    step();
    check($sformatf("%s release", tag), 32'(nDTACK), 1);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    RESET    = 1'b1;
    nAS      = 1'b1;
    ZONE_SEL = '0;
    ZONE_WS  = {3'd3, 3'd0, 3'd2, 3'd0};
    ZONE_EXT = '0;
    nPDTACK  = 1'b1;
    WDKICK   = 1'b0;
    #2;
    check("rst ndtack", 32'(nDTACK), 1);
    check("rst nberr", 32'(nBERR), 1);
    check("rst nwdreset", 32'(nWDRESET), 1);
    check("rst zone", 32'(CUR_ZONE), 0);

    // Watchdog, no kicks: pulse low after edges 100..115.
    do_reset();
    for (int j = 1; j <= 120; j++) begin
      step();
      check($sformatf("wd free %0d", j), 32'(nWDRESET), (j >= 100 && j <= 115) ? 0 : 1);
    end

    // Watchdog kicked every 50 clocks: never fires.
    do_reset();
    for (int j = 1; j <= 260; j++) begin
      WDKICK = (j % 50 == 0);
      step();
      check($sformatf("wd kick50 %0d", j), 32'(nWDRESET), 1);
    end
    WDKICK = 1'b0;

    // Kick on the terminal edge wins.
    do_reset();
    for (int j = 1; j <= 140; j++) begin
      WDKICK = (j == 100);
      step();
      check($sformatf("wd kickterm %0d", j), 32'(nWDRESET), 1);
    end
    WDKICK = 1'b0;

    // Plain wait-state cycles.
    do_reset();
    bus_cycle("z1 ws2", 4'b0010, 3, 1);
    bus_cycle("z0 ws0", 4'b0001, 1, 0);
    bus_cycle("z12 prio", 4'b0110, 3, 1);
    bus_cycle("z3 ws3", 4'b1000, 4, 3);
    bus_cycle("z2 ws0", 4'b0100, 1, 2);

    // Zone 3 external: nPDTACK sampled low at edge k+5, nDTACK low after k+6.
    ZONE_EXT = 4'b1000;
    nAS = 1'b0;
    ZONE_SEL = 4'b1000;
    step();
    for (int j = 1; j <= 6; j++) begin
      step();
      check($sformatf("ext dtack%0d", j), 32'(nDTACK), (j == 6) ? 0 : 1);
      if (j == 4) nPDTACK = 1'b0;
    end
    nAS = 1'b1;
    nPDTACK = 1'b1;
    ZONE_SEL = '0;
    step();
    check("ext release", 32'(nDTACK), 1);

    // Zone 3 external, nPDTACK never comes: bus error after 20 edges.
    nAS = 1'b0;
    ZONE_SEL = 4'b1000;
    step();
    for (int j = 1; j <= 22; j++) begin
      step();
      check($sformatf("ext to berr%0d", j), 32'(nBERR), (j >= 20) ? 0 : 1);
      check($sformatf("ext to dtack%0d", j), 32'(nDTACK), 1);
    end
    nAS = 1'b1;
    ZONE_SEL = '0;
    step();
    check("ext to release", 32'(nBERR), 1);

    // nPDTACK on the timeout edge: acknowledge wins.
    nAS = 1'b0;
    ZONE_SEL = 4'b1000;
    step();
    for (int j = 1; j <= 21; j++) begin
      step();
      check($sformatf("tie dtack%0d", j), 32'(nDTACK), (j >= 20) ? 0 : 1);
      check($sformatf("tie berr%0d", j), 32'(nBERR), 1);
      if (j == 18) nPDTACK = 1'b0;
    end
    nAS = 1'b1;
    nPDTACK = 1'b1;
    ZONE_SEL = '0;
    ZONE_EXT = '0;
    step();
    check("tie release", 32'(nDTACK), 1);

    // Unmapped cycle: only the timeout ends it.
    nAS = 1'b0;
    ZONE_SEL = 4'b0000;
    step();
    for (int j = 1; j <= 22; j++) begin
      step();
      check($sformatf("unmap berr%0d", j), 32'(nBERR), (j >= 20) ? 0 : 1);
      check($sformatf("unmap dtack%0d", j), 32'(nDTACK), 1);
    end
    nAS = 1'b1;
    step();
    check("unmap release", 32'(nBERR), 1);

    // Abort in WAIT: no acknowledge, no error.
    nAS = 1'b0;
    ZONE_SEL = 4'b1000;
    step();
    step();
    nAS = 1'b1;
    ZONE_SEL = '0;
    for (int j = 1; j <= 5; j++) begin
      step();
      check($sformatf("abort dtack%0d", j), 32'(nDTACK), 1);
      check($sformatf("abort berr%0d", j), 32'(nBERR), 1);
    end
    bus_cycle("after abort", 4'b0010, 3, 1);

    // Asynchronous reset while in ACK.
    nAS = 1'b0;
    ZONE_SEL = 4'b0100;
    step();
    step();
    check("pre-rst dtack", 32'(nDTACK), 0);
    check("pre-rst zone", 32'(CUR_ZONE), 2);
    #2;
    RESET = 1'b1;
    #1;
    check("async rst dtack", 32'(nDTACK), 1);
    check("async rst berr", 32'(nBERR), 1);
    check("async rst zone", 32'(CUR_ZONE), 0);
    check("async rst state", 32'(dut.state_q), 32'(S_IDLE));
    check("async rst wdcnt", 32'(dut.u_wd.cnt_q), 0);
    nAS = 1'b1;
    ZONE_SEL = '0;
    step();
    RESET = 1'b0;
    bus_cycle("post rst", 4'b0001, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neo_buscycle.md
Name: neo_buscycle

Overview:
- Parametrised 68k bus-cycle controller for the NEO-C1 side of the system: generates nDTACK per address zone with configurable wait states and optional external (cartridge nPDTACK) termination.
- Generates nBERR on bus timeout.
- Contains the system watchdog, which pulses a reset request when not kicked.
- Sits between the CPU strobes and the zone decode; replaces the fixed, unwaited DTACK path. The memcard zone becomes "2 wait states" via parameter data.

Parameters:
- NZONES, 4, number of decoded zones (one ZONE_SEL bit each).
- WSW, 3, width of each per-zone wait-state count.
- TOW, 8, width of the bus timeout counter.
- TIMEOUT, 200, clocks from nAS low to nBERR if the cycle has not terminated.
- WDW, 20, width of the watchdog counter.
- WD_LIMIT, 786432, watchdog terminal count in clocks.
- WD_PULSE, 16, length of the nWDRESET pulse in clocks.

Ports:
- CLK_68KCLK  in  1  68k clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- nAS  in  1  68k address strobe, active low.
- ZONE_SEL  in  NZONES  one-hot zone decode, valid while nAS is low.
- ZONE_WS  in  NZONES*WSW  static wait-state count per zone; zone i uses bits [i*WSW +: WSW].
- ZONE_EXT  in  NZONES  1 = the zone waits for nPDTACK after its wait states.
- nPDTACK  in  1  external cartridge DTACK, active low.
- WDKICK  in  1  one-clock watchdog kick; its source is the write to the watchdog register.
- nDTACK  out  1  data acknowledge to the 68k, active low.
- nBERR  out  1  bus error to the 68k, active low.
- nWDRESET  out  1  watchdog reset request, active low.
- CUR_ZONE  out  $clog2(NZONES)  index of the zone of the current or last cycle (debug).

Behaviour:
- Reset state: FSM=IDLE; nDTACK=1, nBERR=1, nWDRESET=1, CUR_ZONE=0; all counters 0.
- FSM states: IDLE, WAIT, EXTW, ACK, BERR.
- IDLE
  - On an edge where nAS=0, the zone is the lowest set bit of ZONE_SEL. Load WS=ZONE_WS[zone], TO=0, latch EXT=ZONE_EXT[zone], set CUR_ZONE.
  - Next state: WAIT if WS>0; else EXTW if EXT; else ACK.
  - ZONE_SEL all zero (unmapped): go to WAIT with WS treated as infinite. Only the timeout terminates the cycle.
- WAIT
  - WS decrements each clock.
  - When it would reach 0, go to EXTW if EXT, else ACK.
- EXTW: go to ACK on the first edge that samples nPDTACK=0.
- ACK: nDTACK=0, held until nAS is sampled high. Then nDTACK=1 in the same registered update and the FSM returns to IDLE.
- BERR: nBERR=0 until nAS is sampled high. Then nBERR=1 and the FSM returns to IDLE. nDTACK stays 1 throughout.
- Latency: nAS sampled low at edge k with WS=N and no EXT gives nDTACK low after edge k+1+N. WS=0 gives low after edge k+1.
- Timeout
  - TO increments in WAIT and EXTW.
  - When TO reaches TIMEOUT-1 the FSM goes to BERR.
  - In EXTW, if nPDTACK=0 on the same edge, ACK wins over BERR.
  - TO saturates and does not wrap.
- Abort: nAS sampled high in WAIT or EXTW returns the FSM to IDLE with no acknowledge. A back-to-back cycle needs nAS high for at least one edge.
- nDTACK and nBERR are never low simultaneously.
- Watchdog
  - Counter increments every clock.
  - WDKICK=1 clears it to 0. A kick takes priority over the terminal count on the same edge.
  - At WD_LIMIT-1: nWDRESET goes low for exactly WD_PULSE clocks and the counter clears. Kicks are ignored during the pulse.
  - The watchdog runs independently of the bus FSM.
- RESET asserted mid-operation immediately forces all outputs to their reset values, asynchronously.

Decomposition:
- Shared package neo_pkg holds:
  - the bus FSM state enum;
  - the zone index constants (ZONE_ROM, ZONE_PORT, ZONE_MEMCARD, ZONE_IO);
  - the default wait-state constants, including MEMCARD_WS=2.
- One sub-module, neo_watchdog (counter plus pulse stretcher; parameters WDW, WD_LIMIT, WD_PULSE), instantiated once.

Test Plan:
- NZONES=4, ZONE_WS={0,2,0,3}, ZONE_EXT=0. nAS low at edge 10 with ZONE_SEL=4'b0010 -> nDTACK low after edge 13, high after the first edge sampling nAS=1, CUR_ZONE=1.
- Zone 0 with WS=0 -> nDTACK low after edge 11. ZONE_SEL=4'b0110 -> zone 1 chosen, 2 wait states.
- Zone 3 with EXT=1, WS=3, nPDTACK low 5 clocks after nAS -> nDTACK low one edge after nPDTACK is sampled. nPDTACK never asserted -> nBERR low at TIMEOUT edges, nDTACK stays 1.
- ZONE_SEL=0 with nAS held low -> nBERR low after TIMEOUT edges. nAS released mid-WAIT -> back to IDLE, neither nDTACK nor nBERR asserted.
- WD_LIMIT=100, WD_PULSE=16, no kicks -> nWDRESET low for edges 100..115. Kick every 50 clocks -> nWDRESET stays 1. Kick on the terminal edge -> no pulse.
- RESET pulsed while in ACK -> nDTACK=1 immediately, FSM in IDLE, watchdog counter 0.
